// File: rtl/lsu_byte_lane.sv
// Load/store front end for the byte-addressable sparse memory.
// Splits misaligned halfwords into two byte transactions and extends loads.
module lsu_byte_lane #(
  parameter int XLEN  = 32,
  parameter int BADDR = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic            mem_rd_o,
  output logic            mem_gwe_o,
  output logic [3:0]      mem_bw_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_ISSUE1,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_n;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            err_q;
  logic [7:0]      lo_q;

  logic            acc;
  logic            ill;
  logic            c_we;
  logic [2:0]      c_f3;
  logic [XLEN-1:0] c_addr;
  logic [XLEN-1:0] c_wdata;
  logic            c_err;
  logic            c_split;
  logic [BADDR-1:0] off;
  logic [BADDR-1:0] off1;

  logic            rd_n;
  logic            gwe_n;
  logic [3:0]      bw_n;
  logic [XLEN-1:0] maddr_n;
  logic [XLEN-1:0] mwdata_n;
  logic [XLEN-1:0] rdata_n;

  logic [7:0]      b_b;
  logic [7:0]      hi_b;
  logic [15:0]     h_h;
  logic            sx;

  assign req_ready_o = (state_q == S_IDLE);
  assign acc = req_valid_i & req_ready_o;

  always_comb begin
    ill = 1'b0;
    unique case (req_funct3_i)
      3'b000,
      3'b001: ill = 1'b0;
      3'b010: ill = |req_addr_i[1:0];
      3'b100,
      3'b101: ill = req_we_i;
      default: ill = 1'b1;
    endcase
  end

  // On the accept cycle the strobes are built from the live request.
  always_comb begin
    c_we    = acc ? req_we_i     : we_q;
    c_f3    = acc ? req_funct3_i : f3_q;
    c_addr  = acc ? req_addr_i   : addr_q;
    c_wdata = acc ? req_wdata_i  : wdata_q;
    c_err   = acc ? ill          : err_q;
    off     = c_addr[BADDR-1:0];
    off1    = off + BADDR'(1);
    c_split = (c_f3[1:0] == 2'b01) & off[0];
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc) state_n = ill ? S_RESP : S_ISSUE0;
      end
      S_ISSUE0: begin
        if (c_split)   state_n = S_ISSUE1;
        else if (c_we) state_n = S_RESP;
        else           state_n = S_WAIT;
      end
      S_ISSUE1: state_n = c_we ? S_RESP : S_WAIT;
      S_WAIT:   state_n = S_RESP;
      S_RESP:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rd_n     = 1'b0;
    gwe_n    = 1'b0;
    bw_n     = 4'b0000;
    maddr_n  = '0;
    mwdata_n = '0;
    if (state_n == S_ISSUE0) begin
      maddr_n = c_addr;
      if (!c_we) begin
        rd_n = 1'b1;
      end else begin
        case (c_f3[1:0])
          2'b10: begin
            gwe_n    = 1'b1;
            mwdata_n = c_wdata;
          end
          2'b01: begin
            if (c_split) begin
              bw_n     = 4'b0001 << off;
              mwdata_n = XLEN'(c_wdata[7:0]);
            end else begin
              bw_n     = 4'b0011 << off;
              mwdata_n = XLEN'(c_wdata[15:0]);
            end
          end
          default: begin
            bw_n     = 4'b0001 << off;
            mwdata_n = XLEN'(c_wdata[7:0]);
          end
        endcase
      end
    end else if (state_n == S_ISSUE1) begin
      maddr_n = c_addr + XLEN'(1);
      rd_n    = ~c_we;
      if (c_we) begin
        bw_n     = 4'b0001 << off1;
        mwdata_n = XLEN'(c_wdata[15:8]);
      end
    end
  end

  // Memory returns lane-positioned words; pick the lanes and extend.
  always_comb begin
    b_b  = 8'(mem_rdata_i >> {off, 3'b000});
    hi_b = 8'(mem_rdata_i >> {off1, 3'b000});
    h_h  = c_split ? {hi_b, lo_q}
                   : 16'(mem_rdata_i >> {off, 3'b000});
    sx   = ~c_f3[2];
    rdata_n = '0;
    if (state_q == S_WAIT) begin
      case (c_f3[1:0])
        2'b00:   rdata_n = {{(XLEN-8){sx & b_b[7]}}, b_b};
        2'b01:   rdata_n = {{(XLEN-16){sx & h_h[15]}}, h_h};
        default: rdata_n = mem_rdata_i;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      lo_q         <= 8'h00;
      mem_rd_o     <= 1'b0;
      mem_gwe_o    <= 1'b0;
      mem_bw_o     <= 4'b0000;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      state_q <= state_n;
      if (acc) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= ill;
      end
      if (state_q == S_ISSUE1) lo_q <= b_b;
      mem_rd_o     <= rd_n;
      mem_gwe_o    <= gwe_n;
      mem_bw_o     <= bw_n;
      mem_addr_o   <= maddr_n;
      mem_wdata_o  <= mwdata_n;
      resp_valid_o <= (state_n == S_RESP);
      resp_err_o   <= (state_n == S_RESP) & c_err;
      resp_rdata_o <= rdata_n;
    end
  end

endmodule

// File: doc/lsu_byte_lane.md
Name: lsu_byte_lane

Overview:
Load/store front end that sits directly upstream of the byte-addressable sparse memory and drives one of its ports. It accepts one CPU load/store request at a time in RISC-V funct3 encoding, generates the memory's read, global-write and per-byte write strobes, and splits misaligned halfword accesses into two byte transactions. Load data is aligned and sign/zero-extended before it is returned to the core.

Parameters:
XLEN, 32, word and address width; the block supports only 32.
BADDR, 2, number of byte-offset address bits.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset: synchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid and ready are both 1
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr_i  in  XLEN  byte address
req_wdata_i  in  XLEN  store data, right-aligned
resp_valid_o  out  1  one-cycle response pulse
resp_rdata_o  out  XLEN  extended load data; 0 for stores and errors
resp_err_o  out  1  illegal or misaligned request
mem_rd_o  out  1  memory read strobe
mem_gwe_o  out  1  memory full-word write
mem_bw_o  out  4  byte-lane writes, bit k drives lane k (bw0..bw3)
mem_addr_o  out  XLEN  memory byte address
mem_wdata_o  out  XLEN  memory write data
mem_rdata_i  in  XLEN  memory read data, valid the cycle after mem_rd_o

Behaviour:
- Reset (rst_ni low at a rising edge): state goes to IDLE; all outputs are 0 except req_ready_o = 1. Reset during any state aborts the operation with no response and no further strobes.
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT, RESP. req_ready_o = 1 only in IDLE. There is one outstanding request at most.
- On accept in IDLE, addr, funct3, we and wdata are registered.
  - Illegal encodings go to RESP with err = 1. Illegal means funct3 outside the 5 listed codes, store with funct3 100 or 101, or a word access with addr[1:0] != 0.
  - All other requests go to ISSUE0.
- Memory strobes are registered outputs. They are asserted only during ISSUE0 and ISSUE1, and are 0 in every other state.
- Store lane mapping, o = addr[1:0]. Data is placed as the memory expects it.
  - Word: gwe = 1, addr = req address, wdata = full word.
  - Byte at offset o: bw[o] = 1, wdata[7:0] = byte.
  - Half at o = 0: bw = 0011, wdata[15:0] = half.
  - Half at o = 2: bw = 1100, wdata[15:0] = half.
  - Half at o = 1 (split): ISSUE0 sets bw = 0010, wdata[7:0] = d[7:0], addr = A. ISSUE1 sets bw = 0100, wdata[7:0] = d[15:8], addr = A + 1.
  - Half at o = 3 (split, crosses word): ISSUE0 sets bw = 1000, addr = A. ISSUE1 sets bw = 0001, addr = A + 1, wrapping modulo 2^XLEN.
- Loads: rd = 1 with addr in ISSUE0. Split loads also assert rd = 1 in ISSUE1 with addr = A + 1.
  - First-read data is captured in the cycle after ISSUE0; second-read data is captured in WAIT.
  - Extraction: byte = lane o. Half = lanes o and o+1. Split half = lane o of the first read (low byte) and lane (o+1) mod 4 of the second read (high byte).
  - B and H sign-extend; BU and HU zero-extend.
- Transitions:
  - ISSUE0 goes to ISSUE1 if the access is split; otherwise to WAIT for loads and to RESP for stores.
  - ISSUE1 goes to WAIT for loads and to RESP for stores.
  - WAIT goes to RESP.
  - RESP goes to IDLE.
- In RESP, resp_valid_o = 1 for exactly one cycle; the response is not backpressured.
- Latency, counting the accept edge as cycle 0, to the response cycle:
  - Error: 1.
  - Aligned store: 2.
  - Aligned load: 3.
  - Split store: 3.
  - Split load: 4.
- A new request can be accepted in the cycle following RESP.

Test Plan:
- Aligned SW 0x40000000 = 0xDEADBEEF, then LW -> gwe pulse with bw = 0000; resp at cycle 2; load resp at cycle 3 with rdata 0xDEADBEEF, err 0.
- SB 0x80 at 0x40000003, then LB and LBU -> bw = 1000 with wdata[7:0] = 0x80; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH 0xA55A at 0x40000001 (split) -> ISSUE0 bw = 0010 with wdata[7:0] = 0x5A; ISSUE1 bw = 0100 with wdata[7:0] = 0xA5; LH returns 0xFFFFA55A at cycle 4.
- SH 0x1234 at 0x40000003 (word crossing) -> addresses 0x40000003 then 0x40000004 with bw 1000 then 0001; LHU returns 0x00001234.
- LW at 0x40000002 and funct3 = 011 -> resp at cycle 1 with err = 1, rdata 0, no mem strobes.
- rst_ni low during ISSUE1 of a split store -> strobes 0 next cycle, no resp_valid, req_ready_o = 1.
